flow_hash_steer: RTL
====================

Name: flow_hash_steer

Overview:
- Sits directly downstream of the 8-stage flow hash pipeline.
- Taps the same tuple stream the hash stage ingests and queues each accepted tuple in order.
- Pairs each tuple with its 32-bit hash when that hash emerges, then maps the hash to a queue ID through a writable indirection table (RSS-style).
- Emits {tuple, hash, qid} on a valid/ready interface and drives the shared `stall` that freezes the hash pipeline and upstream.

Parameters:
- HASH_LAT, 8, edges from an accepted tuple to its `hashed_valid` at the hash stage.
- TBL_BITS, 7, indirection table index width; the table has 128 entries.
- QID_W, 9, queue ID width.
- RES_DEPTH, 16, result FIFO depth; power of two, ≥4.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- tuple_in  in  tuple_t  same tuple bus presented to the hash stage.
- tuple_in_valid  in  1  same valid presented to the hash stage.
- stall  out  1  registered; drives the hash stage `stall` and upstream.
- hashed  in  32  hash result.
- hashed_valid  in  1  hash result valid.
- tbl_wr_en  in  1  table write strobe.
- tbl_wr_addr  in  TBL_BITS  table write index.
- tbl_wr_data  in  QID_W  queue ID to store.
- out_tuple  out  tuple_t  tuple paired with the hash.
- out_hash  out  32  hash value.
- out_qid  out  QID_W  table lookup result.
- out_valid  out  1  result available.
- out_ready  in  1  consumer ready.
- err_order  out  1  sticky: a hash arrived with no pending tuple.

Behaviour:
- Reset (rst=0, asynchronous):
  - stall=0, out_valid=0, err_order=0, out_* data=0.
  - FIFOs empty; table all 0; warm-up counter=0; stall_d1=0.
- Accept: accept = tuple_in_valid && !stall. On accept, push tuple_in into the tuple FIFO (depth HASH_LAT).
- Hash stage is not reset. After reset deassertion, ignore hashed_valid for the first HASH_LAT cycles (warm-up counter saturates at HASH_LAT).
  - A tuple accepted in the first post-reset cycle appears at cycle HASH_LAT and is captured.
- Freshness: stall_d1 registers `stall`. A held result (hash stage frozen) is never re-captured.
  - capture = hashed_valid && warm_done && !stall_d1.
- On capture, in the same edge:
  - pop the tuple FIFO;
  - read table[hashed[TBL_BITS-1:0]];
  - push {tuple, hashed, qid} into the result FIFO.
- Capture with the tuple FIFO empty: set err_order (sticky until reset) and push with tuple = 0.
- Table write vs lookup:
  - The write takes effect at the edge.
  - A lookup in the same cycle to the same address returns the old value.
- Stall:
  - stall <= (res_cnt_next >= RES_DEPTH-1), where res_cnt_next includes this edge's push and pop.
  - One fresh capture can still occur in the first stalled cycle, so the result FIFO peaks at RES_DEPTH and never overflows.
  - Tuple FIFO occupancy ≤ HASH_LAT by construction; overflow is impossible.
- Output:
  - out_valid = result FIFO non-empty; out_* = head.
  - Pop on out_valid && out_ready.
  - Capture edge to out_valid high is 1 cycle when the FIFO was empty.
  - out_* hold stable while out_valid && !out_ready.
- Simultaneous push/pop on the result FIFO: count unchanged; when full, the pop frees the slot for the push.
- Order is preserved: output order equals accept order.

Decomposition:
- Shared package (constants.sv): tuple_t (existing), HASH_LAT, result struct {tuple_t, hash, qid}.
- Sub-module `steer_fifo`: parameterised width/depth, show-ahead, with count output. Instantiated twice (tuple FIFO, result FIFO).
- Table and stall/capture logic live in the top module.

Test Plan:
- Single flow: after reset, write table[0x15]=9'd37. Send one tuple whose hash has low 7 bits 0x15 → 9 cycles after accept, out_valid=1, out_qid=37, out_hash equals the golden Jenkins value, out_tuple equals the input.
- Back-to-back: 32 tuples, out_ready=1 → 32 outputs in order, no stall, err_order=0.
- Backpressure: out_ready=0 while streaming → stall rises when occupancy reaches 15; exactly 16 results buffered. Raise out_ready → all tuples emerge in order, none duplicated or lost.
- Stall during in-flight: hold out_ready=0 so the stall freezes the hash stage with a valid result held for 5 cycles → captured exactly once.
- Table write collision: write table[3]=9 in the same cycle a hash with index 3 is captured (old value 0) → qid=0; the next such hash → qid=9.
- Mid-stream reset: pulse rst low with 6 tuples in flight → outputs clear, stall=0. The hash stage's stale hashed_valid pulses within the first 8 cycles produce no output and no err_order.

Source files
------------

// File: rtl/flow_hash_steer_pkg.sv
// Shared types and sizing for the flow hash steering block.
// The result record pairs the tuple with its hash and the queue ID it was steered to.
package flow_hash_steer_pkg;

    localparam int HASH_LAT    = 8;
    localparam int TBL_BITS    = 7;
    localparam int TBL_ENTRIES = 1 << TBL_BITS;
    localparam int QID_W       = 9;
    localparam int RES_DEPTH   = 16;

    typedef struct packed {
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [7:0]  proto;
    } tuple_t;

    typedef struct packed {
        tuple_t             tuple;
        logic [31:0]        hash;
        logic [QID_W-1:0]   qid;
    } result_t;

endpackage

// File: rtl/steer_fifo.sv
// Show-ahead FIFO with occupancy count; head reads 0 while empty, no write-through.
// A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
module steer_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [W-1:0]  i_dat,
    input  logic          i_pop,
    output logic [W-1:0]  o_dat,
    output logic [AW:0]   o_count
);

    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_FULL);
    assign w_pop   = i_pop && !w_empty;
    assign w_push  = i_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_dat;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    assign o_dat   = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/flow_hash_steer.sv
// Pairs queued tuples with hashes from the 8-stage hash pipeline and steers them via an indirection table.
// Capture to out_valid is one cycle; stall throttles the hash pipeline and upstream when results back up.
module flow_hash_steer
    import flow_hash_steer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  tuple_t               tuple_in,
    input  logic                 tuple_in_valid,
    output logic                 stall,
    input  logic [31:0]          hashed,
    input  logic                 hashed_valid,
    input  logic                 tbl_wr_en,
    input  logic [TBL_BITS-1:0]  tbl_wr_addr,
    input  logic [QID_W-1:0]     tbl_wr_data,
    output tuple_t               out_tuple,
    output logic [31:0]          out_hash,
    output logic [QID_W-1:0]     out_qid,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 err_order
);

    localparam int TUP_CW = $clog2(HASH_LAT) + 1;
    localparam int RES_CW = $clog2(RES_DEPTH) + 1;
    localparam int WARM_W = $clog2(HASH_LAT + 1);

    logic [QID_W-1:0]  r_tbl [TBL_ENTRIES];
    logic [WARM_W-1:0] r_warm_cnt;
    logic              r_stall;
    logic              r_stall_d1;
    logic              r_err_order;

    logic              w_accept;
    logic              w_warm_done;
    logic              w_capture;
    logic              w_tup_empty;
    logic              w_res_pop;
    tuple_t            w_tup_head;
    logic [TUP_CW-1:0] w_tup_cnt;
    result_t           w_res_push_dat;
    result_t           w_res_head;
    logic [RES_CW-1:0] w_res_cnt;
    logic [RES_CW-1:0] w_res_cnt_next;

    assign w_accept    = tuple_in_valid && !r_stall;
    assign w_warm_done = (r_warm_cnt == WARM_W'(HASH_LAT));
    // A result held by a frozen hash stage was already taken on the first stalled cycle.
    assign w_capture   = hashed_valid && w_warm_done && !r_stall_d1;
    assign w_tup_empty = (w_tup_cnt == '0);
    assign w_res_pop   = out_valid && out_ready;

    always_comb begin
        w_res_push_dat       = '0;
        w_res_push_dat.tuple = w_tup_head;
        w_res_push_dat.hash  = hashed;
        w_res_push_dat.qid   = r_tbl[hashed[TBL_BITS-1:0]];
    end

    assign w_res_cnt_next = w_res_cnt + RES_CW'(w_capture) - RES_CW'(w_res_pop);

    steer_fifo #(
        .W     ($bits(tuple_t)),
        .DEPTH (HASH_LAT)
    ) u_tup_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_accept),
        .i_dat   (tuple_in),
        .i_pop   (w_capture),
        .o_dat   (w_tup_head),
        .o_count (w_tup_cnt)
    );

    steer_fifo #(
        .W     ($bits(result_t)),
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_capture),
        .i_dat   (w_res_push_dat),
        .i_pop   (w_res_pop),
        .o_dat   (w_res_head),
        .o_count (w_res_cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TBL_ENTRIES; i++) begin
                r_tbl[i] <= '0;
            end
        end else if (tbl_wr_en) begin
            r_tbl[tbl_wr_addr] <= tbl_wr_data;
        end
    end

    // Stall one entry early: the capture already in flight on the first stalled cycle fills the last slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_warm_cnt  <= '0;
            r_stall     <= 1'b0;
            r_stall_d1  <= 1'b0;
            r_err_order <= 1'b0;
        end else begin
            if (!w_warm_done) begin
                r_warm_cnt <= r_warm_cnt + WARM_W'(1);
            end
            r_stall    <= (w_res_cnt_next >= RES_CW'(RES_DEPTH - 1));
            r_stall_d1 <= r_stall;
            if (w_capture && w_tup_empty) begin
                r_err_order <= 1'b1;
            end
        end
    end

    assign stall     = r_stall;
    assign err_order = r_err_order;
    assign out_valid = (w_res_cnt != '0);
    assign out_tuple = w_res_head.tuple;
    assign out_hash  = w_res_head.hash;
    assign out_qid   = w_res_head.qid;

endmodule
